pipe_sequencer: RTL and testbench

Run-control and hazard sequencer for the three-stage 16-bit RISC pipeline (IF/ID → ID/EX → EX/WB). It owns the run/halt/single-step state and the data-hazard stall. It also drives taken-branch redirect and flush, operand forwarding selects, and a retired-instruction counter. It sits beside the pipe registers and PC, consumes the three in-flight instruction words plus the ID-stage comparator result, and drives every pipe enable.

---
 rtl/pipe_sequencer_pkg.sv | 57 +++++
 rtl/pipe_sequencer_if.sv | 45 ++++
 rtl/pipe_sequencer_hazard_detect.sv | 52 +++++
 rtl/pipe_sequencer.sv | 151 +++++++++++++++
 tb/tb_pipe_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : risc_ctrl_pkg
//  Purpose  : Shared definitions for the pipeline run-control block. Holds the
//             opcode constants, the NOP word, the run-state encoding, the
//             forwarding-select codes and the instruction field-slice helpers.
//  Revision : 1.0  initial release
// ============================================================================
package risc_ctrl_pkg;

  // Opcode field, ir[15:14]
  localparam logic [1:0] c_op_nop = 2'b00;
  localparam logic [1:0] c_op_add = 2'b01;
  localparam logic [1:0] c_op_and = 2'b10;
  localparam logic [1:0] c_op_beq = 2'b11;

  // A flushed or bubbled pipe register holds this word
  localparam logic [15:0] c_nop_word = 16'h0000;

  // EX operand source selects; 2'b01 is reserved and never produced
  localparam logic [1:0] c_fwd_regfile = 2'b00;
  localparam logic [1:0] c_fwd_wb      = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10,
    ST_STEP = 2'b11
  } run_state_t;

  function automatic logic [1:0] ir_op(input logic [15:0] ir);
    return ir[15:14];
  endfunction

  function automatic logic [2:0] ir_rs(input logic [15:0] ir);
    return ir[13:11];
  endfunction

  function automatic logic [2:0] ir_rt(input logic [15:0] ir);
    return ir[10:8];
  endfunction

  function automatic logic [2:0] ir_dest(input logic [15:0] ir);
    return ir[7:5];
  endfunction

  // ADD and AND write the register file; NOP and BEQ do not
  function automatic logic ir_is_writer(input logic [15:0] ir);
    return (ir[15:14] == c_op_add) || (ir[15:14] == c_op_and);
  endfunction

  function automatic logic ir_is_beq(input logic [15:0] ir);
    return ir[15:14] == c_op_beq;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_sequencer_if
//  Purpose  : Bundles the run-control requests, the in-flight instruction
//             words and the pipe-control outputs of the sequencer.
//  Ports    : slave  - the sequencer (consumes requests/IRs, drives enables)
//             master - the pipeline/controller side driving the requests
//  Revision : 1.0  initial release
// ============================================================================
interface pipe_sequencer_if;

  logic        run_req;
  logic        halt_req;
  logic        step_req;
  logic [15:0] id_ir;
  logic [15:0] ex_ir;
  logic [15:0] wb_ir;
  logic        zero;

  logic        pc_en;
  logic        pc_sel_branch;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_en;
  logic        idex_bubble;
  logic        exwb_en;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [1:0]  state;
  logic [15:0] retired;

  modport slave (
    input  run_req, halt_req, step_req, id_ir, ex_ir, wb_ir, zero,
    output pc_en, pc_sel_branch, ifid_en, ifid_flush, idex_en, idex_bubble,
           exwb_en, fwd_a, fwd_b, state, retired
  );

  modport master (
    output run_req, halt_req, step_req, id_ir, ex_ir, wb_ir, zero,
    input  pc_en, pc_sel_branch, ifid_en, ifid_flush, idex_en, idex_bubble,
           exwb_en, fwd_a, fwd_b, state, retired
  );

endinterface
`default_nettype wire

// File: rtl/pipe_sequencer_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_detect
//  Purpose  : Purely combinational hazard logic. Flags a BEQ in decode that
//             needs a register still being produced by ID/EX or EX/WB, flags
//             a taken branch, and derives the EX operand forwarding selects.
//  Ports    : i_id_ir/i_ex_ir/i_wb_ir - in-flight instruction words
//             i_zero                  - ID-stage comparator equal flag
//             o_stall                 - BEQ must wait one cycle
//             o_branch_taken          - BEQ resolves taken (only when no stall)
//             o_fwd_a/o_fwd_b         - EX operand A/B source selects
//  Revision : 1.0  initial release
// ============================================================================
module hazard_detect
  import risc_ctrl_pkg::*;
(
  input  wire logic [15:0] i_id_ir,
  input  wire logic [15:0] i_ex_ir,
  input  wire logic [15:0] i_wb_ir,
  input  wire logic        i_zero,
  output logic             o_stall,
  output logic             o_branch_taken,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b
);

  logic w_id_beq;
  logic w_ex_hit;
  logic w_wb_hit;

  assign w_id_beq = ir_is_beq(i_id_ir);

  // BEQ compares in decode, so it cannot use the forwarding path: an ex_ir
  // writer is a hazard, and because the regfile has no write-through a
  // wb_ir writer is one too.
  assign w_ex_hit = ir_is_writer(i_ex_ir) &&
                    ((ir_dest(i_ex_ir) == ir_rs(i_id_ir)) ||
                     (ir_dest(i_ex_ir) == ir_rt(i_id_ir)));
  assign w_wb_hit = ir_is_writer(i_wb_ir) &&
                    ((ir_dest(i_wb_ir) == ir_rs(i_id_ir)) ||
                     (ir_dest(i_wb_ir) == ir_rt(i_id_ir)));

  assign o_stall        = w_id_beq && (w_ex_hit || w_wb_hit);
  assign o_branch_taken = w_id_beq && i_zero && !o_stall;

  assign o_fwd_a = (ir_is_writer(i_wb_ir) && (ir_dest(i_wb_ir) == ir_rs(i_ex_ir)))
                   ? c_fwd_wb : c_fwd_regfile;
  assign o_fwd_b = (ir_is_writer(i_wb_ir) && (ir_dest(i_wb_ir) == ir_rt(i_ex_ir)))
                   ? c_fwd_wb : c_fwd_regfile;

endmodule
`default_nettype wire

// File: rtl/pipe_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_sequencer
//  Purpose  : Run-control and hazard sequencer for the three-stage 16-bit
//             pipeline. Owns the IDLE/RUN/HALT/STEP state, the post-branch
//             IF/ID flush counter and the retired-instruction counter, and
//             drives every pipe enable.
//  Ports    : clk   - single clock, rising edge
//             reset - synchronous, active-high
//             bus   - run/halt/step requests, in-flight IRs, zero flag in;
//                     pipe enables, flush/bubble, forwarding selects,
//                     state and retired count out
//  Params   : BRANCH_PENALTY - advancing cycles IF/ID is flushed after a
//                              taken branch, legal range 1..3
//  Revision : 1.0  initial release
// ============================================================================
module pipe_sequencer
  import risc_ctrl_pkg::*;
#(
  parameter int BRANCH_PENALTY = 1
) (
  input  wire logic        clk,
  input  wire logic        reset,
  pipe_sequencer_if.slave  bus
);

  // The taken cycle itself is the first flush cycle, so the counter only
  // covers the remaining BRANCH_PENALTY-1.
  localparam logic [1:0] c_flush_load = 2'(BRANCH_PENALTY - 1);

  run_state_t  r_state;
  run_state_t  w_state_nxt;
  logic [1:0]  r_flush_cnt;
  logic [1:0]  w_flush_cnt_nxt;
  logic [15:0] r_retired;

  logic        w_hz_stall;
  logic        w_hz_taken;
  logic [1:0]  w_hz_fwd_a;
  logic [1:0]  w_hz_fwd_b;

  logic        w_advance;
  logic        w_flushing;
  logic        w_stall;
  logic        w_taken;

  logic        w_pc_en;
  logic        w_pc_sel_branch;
  logic        w_ifid_en;
  logic        w_ifid_flush;
  logic        w_idex_en;
  logic        w_idex_bubble;
  logic        w_exwb_en;

  hazard_detect u_hazard_detect (
    .i_id_ir        (bus.id_ir),
    .i_ex_ir        (bus.ex_ir),
    .i_wb_ir        (bus.wb_ir),
    .i_zero         (bus.zero),
    .o_stall        (w_hz_stall),
    .o_branch_taken (w_hz_taken),
    .o_fwd_a        (w_hz_fwd_a),
    .o_fwd_b        (w_hz_fwd_b)
  );

  // Reset forces a full freeze in the same cycle, before the registers clear
  assign w_advance  = !reset && ((r_state == ST_RUN) || (r_state == ST_STEP));
  // While the flush counter is live, a BEQ in decode is a wrong-path word
  // and is neither stalled on nor resolved.
  assign w_flushing = (r_flush_cnt != 2'd0);
  assign w_stall    = !w_flushing && w_hz_stall;
  assign w_taken    = !w_flushing && w_hz_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= 2'd0;
      r_retired   <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      if (w_advance && (bus.wb_ir != c_nop_word)) begin
        r_retired <= r_retired + 16'd1;
      end
    end
  end

  // Run-state next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.run_req)  w_state_nxt = ST_RUN;
      ST_RUN:  if (bus.halt_req) w_state_nxt = ST_HALT;
      ST_HALT: begin
        if (bus.run_req && !bus.halt_req) begin
          w_state_nxt = ST_RUN;
        end else if (bus.step_req) begin
          w_state_nxt = ST_STEP;
        end
      end
      ST_STEP: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Flush counter next-state and pipe-control outputs
  always_comb begin
    w_flush_cnt_nxt = r_flush_cnt;
    w_pc_en         = 1'b0;
    w_pc_sel_branch = 1'b0;
    w_ifid_en       = 1'b0;
    w_ifid_flush    = 1'b0;
    w_idex_en       = 1'b0;
    w_idex_bubble   = 1'b0;
    w_exwb_en       = 1'b0;
    if (w_advance) begin
      w_pc_en   = 1'b1;
      w_ifid_en = 1'b1;
      w_idex_en = 1'b1;
      w_exwb_en = 1'b1;
      if (w_flushing) begin
        w_ifid_flush    = 1'b1;
        w_flush_cnt_nxt = r_flush_cnt - 2'd1;
      end else if (w_stall) begin
        // Hold PC and IF/ID, push a bubble into ID/EX
        w_pc_en       = 1'b0;
        w_ifid_en     = 1'b0;
        w_idex_bubble = 1'b1;
      end else if (w_taken) begin
        w_pc_sel_branch = 1'b1;
        w_ifid_flush    = 1'b1;
        w_flush_cnt_nxt = c_flush_load;
      end
    end
  end

  assign bus.pc_en         = w_pc_en;
  assign bus.pc_sel_branch = w_pc_sel_branch;
  assign bus.ifid_en       = w_ifid_en;
  assign bus.ifid_flush    = w_ifid_flush;
  assign bus.idex_en       = w_idex_en;
  assign bus.idex_bubble   = w_idex_bubble;
  assign bus.exwb_en       = w_exwb_en;
  // Forwarding is live in every run state; only reset masks it
  assign bus.fwd_a         = reset ? c_fwd_regfile : w_hz_fwd_a;
  assign bus.fwd_b         = reset ? c_fwd_regfile : w_hz_fwd_b;
  assign bus.state         = r_state;
  assign bus.retired       = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_pipe_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_sequencer
//  Purpose  : Directed self-checking bench for pipe_sequencer
//             (BRANCH_PENALTY = 2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_sequencer;

  // Control vector order: {pc_en, pc_sel_branch, ifid_en, ifid_flush,
  //                        idex_en, idex_bubble, exwb_en}
  localparam logic [6:0] c_ctl_freeze = 7'b0000000;
  localparam logic [6:0] c_ctl_normal = 7'b1010101;
  localparam logic [6:0] c_ctl_stall  = 7'b0000111;
  localparam logic [6:0] c_ctl_taken  = 7'b1111101;
  localparam logic [6:0] c_ctl_flush  = 7'b1011101;

  // Instruction words
  localparam logic [15:0] c_nop       = 16'h0000;
  localparam logic [15:0] c_add_r1    = 16'h4020; // ADD dest=1
  localparam logic [15:0] c_and_r3    = 16'h8060; // AND dest=3
  localparam logic [15:0] c_beq_r1_r2 = 16'hCA00; // BEQ rs=1 rt=2
  localparam logic [15:0] c_add_s3_t3 = 16'h5B00; // ADD rs=3 rt=3 dest=0
  localparam logic [15:0] c_add_s3_t5 = 16'h5D00; // ADD rs=3 rt=5 dest=0

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_sequencer_if bus ();

  pipe_sequencer #(.BRANCH_PENALTY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [6:0] ctl;
  assign ctl = {bus.pc_en, bus.pc_sel_branch, bus.ifid_en, bus.ifid_flush,
                bus.idex_en, bus.idex_bubble, bus.exwb_en};

  initial begin
    bus.run_req  = 1'b0;
    bus.halt_req = 1'b0;
    bus.step_req = 1'b0;
    bus.id_ir    = c_nop;
    bus.ex_ir    = c_nop;
    bus.wb_ir    = c_nop;
    bus.zero     = 1'b0;
  end

  // Apply one cycle of inputs on the falling edge and settle before checks;
  // the following rising edge commits them.
  task automatic drive(input logic rst, input logic run, input logic halt,
                       input logic step, input logic [15:0] id,
                       input logic [15:0] ex, input logic [15:0] wb,
                       input logic z);
    @(negedge clk);
    reset        = rst;
    bus.run_req  = run;
    bus.halt_req = halt;
    bus.step_req = step;
    bus.id_ir    = id;
    bus.ex_ir    = ex;
    bus.wb_ir    = wb;
    bus.zero     = z;
    #1;
  endtask

  // Reset then request run; the next drive() call sees state RUN, retired 0
  task automatic go_run();
    drive(1, 0, 0, 0, c_nop, c_nop, c_nop, 0);
    drive(0, 1, 0, 0, c_nop, c_nop, c_nop, 0);
  endtask

  task automatic test_reset();
    // Forwarding inputs that would match, to show reset masks fwd selects
    drive(1, 1, 0, 0, c_nop, c_add_s3_t3, c_and_r3, 0);
    if (bus.state !== 2'b00) begin n_err++; $display("FAIL reset_state got %b want 00", bus.state); end
    n_cmp++;
    if (bus.retired !== 16'h0000) begin n_err++; $display("FAIL reset_retired got %h want 0000", bus.retired); end
    n_cmp++;
    if (ctl !== c_ctl_freeze) begin n_err++; $display("FAIL reset_ctl got %b want %b", ctl, c_ctl_freeze); end
    n_cmp++;
    if ({bus.fwd_a, bus.fwd_b} !== 4'b0000) begin n_err++; $display("FAIL reset_fwd got %b want 0000", {bus.fwd_a, bus.fwd_b}); end
    n_cmp++;
    drive(0, 0, 0, 0, c_nop, c_nop, c_nop, 0);
    if (bus.state !== 2'b00 || ctl !== c_ctl_freeze) begin
      n_err++; $display("FAIL idle_after_reset got state %b ctl %b want 00 %b", bus.state, ctl, c_ctl_freeze);
    end
    n_cmp++;
  endtask

  task automatic test_run();
    drive(0, 1, 0, 0, c_nop, c_nop, c_nop, 0);
    if (bus.state !== 2'b00 || ctl !== c_ctl_freeze) begin
      n_err++; $display("FAIL run_req_cycle got state %b ctl %b want 00 %b", bus.state, ctl, c_ctl_freeze);
    end
    n_cmp++;
    drive(0, 0, 0, 0, c_nop, c_nop, c_nop, 0);
    if (bus.state !== 2'b01) begin n_err++; $display("FAIL run_state got %b want 01", bus.state); end
    n_cmp++;
    if (ctl !== c_ctl_normal) begin n_err++; $display("FAIL run_ctl got %b want %b", ctl, c_ctl_normal); end
    n_cmp++;
    drive(0, 0, 0, 0, c_nop, c_nop, c_nop, 0);
    if (bus.retired !== 16'h0000) begin n_err++; $display("FAIL run_nop_retired got %h want 0000", bus.retired); end
    n_cmp++;
  endtask

  task automatic test_stall();
    // ex_ir writes r1, BEQ reads r1; zero=1 must not resolve the branch
    drive(0, 0, 0, 0, c_beq_r1_r2, c_add_r1, c_nop, 1);
    if (ctl !== c_ctl_stall) begin n_err++; $display("FAIL stall_ex got %b want %b", ctl, c_ctl_stall); end
    n_cmp++;
    // Writer now in EX/WB: no write-through, so one more stall
    drive(0, 0, 0, 0, c_beq_r1_r2, c_nop, c_add_r1, 1);
    if (ctl !== c_ctl_stall) begin n_err++; $display("FAIL stall_wb got %b want %b", ctl, c_ctl_stall); end
    n_cmp++;
    // Hazard cleared, branch not taken
    drive(0, 0, 0, 0, c_beq_r1_r2, c_nop, c_nop, 0);
    if (ctl !== c_ctl_normal) begin n_err++; $display("FAIL stall_release got %b want %b", ctl, c_ctl_normal); end
    n_cmp++;
    if (bus.retired !== 16'h0001) begin n_err++; $display("FAIL stall_retired got %h want 0001", bus.retired); end
    n_cmp++;
  endtask

  task automatic test_branch();
    go_run();
    drive(0, 0, 0, 0, c_beq_r1_r2, c_nop, c_nop, 1);
    if (ctl !== c_ctl_taken) begin n_err++; $display("FAIL branch_taken got %b want %b", ctl, c_ctl_taken); end
    n_cmp++;
    // Wrong-path BEQ with zero=1 is not evaluated during the flush
    drive(0, 0, 0, 0, c_beq_r1_r2, c_nop, c_nop, 1);
    if (ctl !== c_ctl_flush) begin n_err++; $display("FAIL branch_flush2 got %b want %b", ctl, c_ctl_flush); end
    n_cmp++;
    drive(0, 0, 0, 0, c_nop, c_nop, c_nop, 0);
    if (ctl !== c_ctl_normal) begin n_err++; $display("FAIL branch_after got %b want %b", ctl, c_ctl_normal); end
    n_cmp++;
    drive(0, 0, 0, 0, c_beq_r1_r2, c_nop, c_nop, 1);
    if (ctl !== c_ctl_taken) begin n_err++; $display("FAIL branch_again got %b want %b", ctl, c_ctl_taken); end
    n_cmp++;
  endtask

  task automatic test_forward();
    drive(0, 0, 0, 0, c_nop, c_add_s3_t3, c_and_r3, 0);
    if ({bus.fwd_a, bus.fwd_b} !== 4'b1010) begin n_err++; $display("FAIL fwd_both got %b want 1010", {bus.fwd_a, bus.fwd_b}); end
    n_cmp++;
    drive(0, 0, 0, 0, c_nop, c_add_s3_t5, c_and_r3, 0);
    if ({bus.fwd_a, bus.fwd_b} !== 4'b1000) begin n_err++; $display("FAIL fwd_a_only got %b want 1000", {bus.fwd_a, bus.fwd_b}); end
    n_cmp++;
    drive(0, 0, 0, 0, c_nop, c_add_s3_t3, c_nop, 0);
    if ({bus.fwd_a, bus.fwd_b} !== 4'b0000) begin n_err++; $display("FAIL fwd_wb_nop got %b want 0000", {bus.fwd_a, bus.fwd_b}); end
    n_cmp++;
  endtask

  task automatic test_halt_step();
    go_run();
    // Cycle T: halt_req seen but this cycle still advances and retires
    drive(0, 0, 1, 0, c_nop, c_nop, c_add_r1, 0);
    if (bus.state !== 2'b01 || ctl !== c_ctl_normal) begin
      n_err++; $display("FAIL halt_cycle_t got state %b ctl %b want 01 %b", bus.state, ctl, c_ctl_normal);
    end
    n_cmp++;
    drive(0, 0, 1, 0, c_nop, c_nop, c_add_r1, 0);
    if (bus.state !== 2'b10 || ctl !== c_ctl_freeze) begin
      n_err++; $display("FAIL halt_frozen got state %b ctl %b want 10 %b", bus.state, ctl, c_ctl_freeze);
    end
    n_cmp++;
    if (bus.retired !== 16'h0001) begin n_err++; $display("FAIL halt_retired got %h want 0001", bus.retired); end
    n_cmp++;
    // Step request; forwarding still live while halted
    drive(0, 0, 0, 1, c_nop, c_add_s3_t3, c_and_r3, 0);
    if (bus.fwd_a !== 2'b10) begin n_err++; $display("FAIL halt_fwd got %b want 10", bus.fwd_a); end
    n_cmp++;
    drive(0, 0, 0, 0, c_nop, c_nop, c_add_r1, 0);
    if (bus.state !== 2'b11 || ctl !== c_ctl_normal) begin
      n_err++; $display("FAIL step_cycle got state %b ctl %b want 11 %b", bus.state, ctl, c_ctl_normal);
    end
    n_cmp++;
    if (bus.retired !== 16'h0001) begin n_err++; $display("FAIL step_frozen_retired got %h want 0001", bus.retired); end
    n_cmp++;
    drive(0, 0, 0, 0, c_nop, c_nop, c_nop, 0);
    if (bus.state !== 2'b10 || ctl !== c_ctl_freeze) begin
      n_err++; $display("FAIL step_back_halt got state %b ctl %b want 10 %b", bus.state, ctl, c_ctl_freeze);
    end
    n_cmp++;
    if (bus.retired !== 16'h0002) begin n_err++; $display("FAIL step_retired got %h want 0002", bus.retired); end
    n_cmp++;
    // run_req with halt low beats step_req
    drive(0, 1, 0, 1, c_nop, c_nop, c_nop, 0);
    drive(0, 0, 0, 0, c_nop, c_nop, c_nop, 0);
    if (bus.state !== 2'b01) begin n_err++; $display("FAIL run_beats_step got %b want 01", bus.state); end
    n_cmp++;
  endtask

  task automatic test_reset_mid_flush();
    go_run();
    drive(0, 0, 0, 0, c_beq_r1_r2, c_nop, c_and_r3, 1);
    if (ctl !== c_ctl_taken) begin n_err++; $display("FAIL mid_flush_taken got %b want %b", ctl, c_ctl_taken); end
    n_cmp++;
    drive(1, 0, 0, 0, c_nop, c_nop, c_and_r3, 0);
    if (ctl !== c_ctl_freeze) begin n_err++; $display("FAIL mid_flush_reset_ctl got %b want %b", ctl, c_ctl_freeze); end
    n_cmp++;
    if (bus.retired !== 16'h0001) begin n_err++; $display("FAIL mid_flush_pre_retired got %h want 0001", bus.retired); end
    n_cmp++;
    drive(0, 0, 0, 0, c_nop, c_nop, c_nop, 0);
    if (bus.state !== 2'b00 || bus.retired !== 16'h0000) begin
      n_err++; $display("FAIL mid_flush_cleared got state %b retired %h want 00 0000", bus.state, bus.retired);
    end
    n_cmp++;
    drive(0, 1, 0, 0, c_nop, c_nop, c_nop, 0);
    drive(0, 0, 0, 0, c_nop, c_nop, c_nop, 0);
    if (ctl !== c_ctl_normal) begin n_err++; $display("FAIL mid_flush_no_residue got %b want %b", ctl, c_ctl_normal); end
    n_cmp++;
  endtask

  task automatic test_wrap();
    go_run();
    for (int i = 0; i < 65535; i++) begin
      drive(0, 0, 0, 0, c_nop, c_nop, c_add_r1, 0);
    end
    drive(0, 0, 0, 0, c_nop, c_nop, c_add_r1, 0);
    if (bus.retired !== 16'hFFFF) begin n_err++; $display("FAIL wrap_ffff got %h want ffff", bus.retired); end
    n_cmp++;
    drive(0, 0, 0, 0, c_nop, c_nop, c_nop, 0);
    if (bus.retired !== 16'h0000) begin n_err++; $display("FAIL wrap_zero got %h want 0000", bus.retired); end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_run();
    test_stall();
    test_branch();
    test_forward();
    test_halt_step();
    test_reset_mid_flush();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
